cpu_instr_feeder: RTL and testbench

Sequencing front end for the `cpu` block. It holds a small program in internal instruction memory, written through a simple write port. On `start` it issues each instruction to the CPU with a one-cycle `load` pulse and a one-cycle `s` pulse, then waits for `w` to fall and rise again. After each instruction it captures the CPU's `out` and `N`/`V`/`Z` flags. It replaces hand-driven stimulus when the CPU runs instruction sequences on hardware and in regression.

---
 rtl/cpu_instr_feeder_if.sv | 14 +
 rtl/cpu_instr_feeder.sv | 143 ++++++++++++++
 tb/tb_cpu_instr_feeder.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_instr_feeder_if.sv
// rtl/cpu_instr_feeder_if.sv - cpu-side load/start/result bus between the feeder and the cpu
interface cpu_instr_feeder_if;
  logic        load;
  logic        s;
  logic [15:0] in;
  logic        w;
  logic [15:0] out;
  logic        N;
  logic        V;
  logic        Z;

  modport master (output load, s, in, input w, out, N, V, Z);
  modport slave  (input load, s, in, output w, out, N, V, Z);
endinterface

// File: rtl/cpu_instr_feeder.sv
// rtl/cpu_instr_feeder.sv - sequences a stored program into the cpu and captures each result
module cpu_instr_feeder #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                prog_we,
  input  logic [AW-1:0]       prog_addr,
  input  logic [15:0]         prog_data,
  input  logic [AW:0]         num_instr,
  input  logic                start,
  cpu_instr_feeder_if.master  cpu,
  output logic [15:0]         res_out,
  output logic [2:0]          res_nvz,
  output logic [AW-1:0]       pc,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int            CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO  = CW'(TIMEOUT);
  localparam logic [AW:0]   MAXN = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_READY, S_LOAD, S_STRT, S_WLO, S_WHI, S_CAP, S_DONE
  } state_t;

  state_t        state, state_n;
  logic [15:0]   mem [DEPTH];
  logic [AW:0]   count;
  logic [AW:0]   num_clamped;
  logic [CW-1:0] tcnt;
  logic          tmo;
  logic          last;
  logic          accept;
  logic          timeout_hit;

  assign tmo         = (tcnt == TMO);
  assign last        = (({1'b0, pc} + (AW+1)'(1)) == count);
  assign accept      = (state == S_IDLE) && start;
  assign num_clamped = (num_instr > MAXN) ? MAXN : num_instr;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next-state decode; a wait state that has burned its timer budget aborts the run.
  always_comb begin
    state_n     = state;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE:  if (start) state_n = (num_instr == '0) ? S_DONE : S_READY;
      S_READY: begin
        if (cpu.w)    state_n = S_LOAD;
        else if (tmo) begin state_n = S_DONE; timeout_hit = 1'b1; end
      end
      S_LOAD:  state_n = S_STRT;
      S_STRT:  state_n = S_WLO;
      S_WLO: begin
        if (!cpu.w)   state_n = S_WHI;
        else if (tmo) begin state_n = S_DONE; timeout_hit = 1'b1; end
      end
      S_WHI: begin
        if (cpu.w)    state_n = S_CAP;
        else if (tmo) begin state_n = S_DONE; timeout_hit = 1'b1; end
      end
      S_CAP:   state_n = last ? S_DONE : S_LOAD;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Wait timer: restarts on every state change, saturates at the timeout value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 tcnt <= '0;
    else if (state_n != state) tcnt <= '0;
    else if (!tmo)             tcnt <= tcnt + CW'(1);
  end

  // Run bookkeeping: latched count, program counter and the sticky timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      pc    <= '0;
      err   <= 1'b0;
    end else begin
      if (accept) begin
        count <= num_clamped;
        pc    <= '0;
        err   <= 1'b0;
      end else if (state == S_CAP && !last) begin
        pc <= pc + AW'(1);
      end
      if (timeout_hit) err <= 1'b1;
    end
  end

  // CPU drive: load and s are one-cycle strobes trailing LOAD/STRT; in holds between instructions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu.load <= 1'b0;
      cpu.s    <= 1'b0;
      cpu.in   <= '0;
    end else begin
      cpu.load <= (state == S_LOAD);
      cpu.s    <= (state == S_STRT);
      if (state == S_LOAD) cpu.in <= mem[pc];
    end
  end

  // Run status: busy drops in the same cycle the done pulse appears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state != S_IDLE) && (state != S_DONE);
      done <= (state == S_DONE);
    end
  end

  // Result capture from the cpu while it sits idle at the end of an instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_out <= '0;
      res_nvz <= '0;
    end else if (state == S_CAP) begin
      res_out <= cpu.out;
      res_nvz <= {cpu.N, cpu.V, cpu.Z};
    end
  end

  // Program memory write port, open only while idle; contents survive reset.
  always_ff @(posedge clk) begin
    if (prog_we && state == S_IDLE) mem[prog_addr] <= prog_data;
  end

endmodule

// File: tb/tb_cpu_instr_feeder.sv
// tb/tb_cpu_instr_feeder.sv - self-checking bench for cpu_instr_feeder
module tb_cpu_instr_feeder;
  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int TIMEOUT = 255;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [15:0]   prog_data = '0;
  logic [AW:0]   num_instr = '0;
  logic          start = 1'b0;
  logic [15:0]   res_out;
  logic [2:0]    res_nvz;
  logic [AW-1:0] pc;
  logic          busy, done, err;

  cpu_instr_feeder_if bif ();

  cpu_instr_feeder #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .num_instr(num_instr), .start(start), .cpu(bif),
    .res_out(res_out), .res_nvz(res_nvz), .pc(pc), .busy(busy), .done(done), .err(err)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] okey = 16'hFFFF;
  int rmode = 1;
  int lo_d = 1;
  int hi_d = 4;
  int tlo = 0;
  int thi = 0;
  int load_total = 0;
  int s_total = 0;
  int done_total = 0;
  bit overlap = 1'b0;
  logic [15:0] in_log[$];
  logic [15:0] prog_m [DEPTH];

  always #5 clk = ~clk;

  // cpu stand-in: result is the issued word xor a per-run key, flags follow the result
  assign bif.out = bif.in ^ okey;
  assign bif.N   = bif.out[15];
  assign bif.V   = ^bif.out;
  assign bif.Z   = (bif.out == 16'h0000);

  // Responder: mode 0 drops w lo_d cycles after s and raises it hi_d cycles later;
  // mode 1 holds w high forever; mode 2 holds w low.
  always @(negedge clk) begin
    if (rmode == 1) begin
      bif.w = 1'b1; tlo = 0; thi = 0;
    end else if (rmode == 2) begin
      bif.w = 1'b0; tlo = 0; thi = 0;
    end else if (bif.s) begin
      tlo = lo_d;
    end else if (tlo > 0) begin
      tlo = tlo - 1;
      if (tlo == 0) begin bif.w = 1'b0; thi = hi_d; end
    end else if (thi > 0) begin
      thi = thi - 1;
      if (thi == 0) bif.w = 1'b1;
    end else begin
      bif.w = 1'b1;
    end
  end

  // Activity monitor: pulse counts, issued words, load/s overlap.
  always @(negedge clk) begin
    if (bif.load === 1'b1) begin in_log.push_back(bif.in); load_total++; end
    if (bif.s === 1'b1) s_total++;
    if (bif.load === 1'b1 && bif.s === 1'b1) overlap = 1'b1;
    if (done === 1'b1) done_total++;
  end

  function automatic logic [2:0] nvz_of(input logic [15:0] r);
    return {r[15], ^r, (r == 16'h0000)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mem(input int a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = AW'(a); prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic do_start(input int n);
    num_instr = (AW+1)'(n); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < bound) begin tick(); cyc++; end
    chk(tag, {31'b0, done}, 32'd1);
  endtask

  // mode 0: plain run; 1: write mem[1] while busy (must be ignored);
  // 2: write mem[0] in the same cycle as start (must be issued)
  task automatic run_check(input string tag, input int n, input int mode, input logic [15:0] wd);
    int m, bl, bs, bd, cyc;
    logic [15:0] last_w;
    m  = (n > DEPTH) ? DEPTH : n;
    bl = load_total; bs = s_total; bd = done_total;
    if (mode == 2) begin
      prog_we = 1'b1; prog_addr = '0; prog_data = wd;
      prog_m[0] = wd;
    end
    do_start(n);
    prog_we = 1'b0;
    if (mode == 1) write_mem(1, wd);
    wait_done({tag, ".done"}, 3000, cyc);
    tick();
    chk({tag, ".done_pulse"}, {31'b0, done}, 32'd0);
    chk({tag, ".loads"}, load_total - bl, m);
    chk({tag, ".strobes"}, s_total - bs, m);
    chk({tag, ".done_cnt"}, done_total - bd, 1);
    for (int i = 0; i < m; i++)
      if (bl + i < in_log.size()) chk({tag, ".in"}, {16'b0, in_log[bl + i]}, {16'b0, prog_m[i]});
    last_w = prog_m[m - 1] ^ okey;
    chk({tag, ".res_out"}, {16'b0, res_out}, {16'b0, last_w});
    chk({tag, ".res_nvz"}, {29'b0, res_nvz}, {29'b0, nvz_of(last_w)});
    chk({tag, ".pc"}, {28'b0, pc}, m - 1);
    chk({tag, ".err"}, {31'b0, err}, 32'd0);
    chk({tag, ".busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int bl, bs, cyc, n;

    // reset with the responder idle
    rmode = 1; reset = 1'b1;
    repeat (3) tick();
    chk("rst.load", {31'b0, bif.load}, 0);
    chk("rst.s", {31'b0, bif.s}, 0);
    chk("rst.in", {16'b0, bif.in}, 0);
    chk("rst.res_out", {16'b0, res_out}, 0);
    chk("rst.res_nvz", {29'b0, res_nvz}, 0);
    chk("rst.pc", {28'b0, pc}, 0);
    chk("rst.busy", {31'b0, busy}, 0);
    chk("rst.done", {31'b0, done}, 0);
    chk("rst.err", {31'b0, err}, 0);
    reset = 1'b0;
    tick();

    // three-instruction program, out = ~in
    write_mem(0, 16'hD007); prog_m[0] = 16'hD007;
    write_mem(1, 16'hD11F); prog_m[1] = 16'hD11F;
    write_mem(2, 16'hA148); prog_m[2] = 16'hA148;
    okey = 16'hFFFF; lo_d = 1; hi_d = 4; rmode = 0;
    run_check("plan", 3, 0, 16'h0);
    chk("plan.res_5eb7", {16'b0, res_out}, 32'h5EB7);

    // zero-length run
    bl = load_total; bs = s_total;
    do_start(0);
    chk("zero.done_k", {31'b0, done}, 0);
    chk("zero.busy", {31'b0, busy}, 0);
    tick();
    chk("zero.done_k1", {31'b0, done}, 1);
    tick();
    chk("zero.done_k2", {31'b0, done}, 0);
    chk("zero.loads", load_total - bl, 0);
    chk("zero.strobes", s_total - bs, 0);
    chk("zero.err", {31'b0, err}, 0);

    // cpu never drops w after s
    rmode = 1;
    do_start(1);
    wait_done("tmo.done", 400, cyc);
    chk("tmo.err", {31'b0, err}, 1);
    chk("tmo.pc", {28'b0, pc}, 0);
    chk("tmo.window", {31'b0, (cyc >= TIMEOUT && cyc <= TIMEOUT + 10)}, 1);
    tick();
    rmode = 0;
    do_start(1);
    chk("tmo.err_clr", {31'b0, err}, 0);
    wait_done("tmo.rerun", 400, cyc);
    tick();

    // cpu busy before start: feeder must sit in READY
    rmode = 2;
    tick();
    bl = load_total;
    do_start(1);
    repeat (10) tick();
    chk("hold.no_load", load_total - bl, 0);
    chk("hold.busy", {31'b0, busy}, 1);
    rmode = 0;
    tick();
    chk("hold.load_p1", {31'b0, bif.load}, 0);
    tick();
    chk("hold.load_p2", {31'b0, bif.load}, 1);
    wait_done("hold.done", 400, cyc);
    tick();

    // write port gating
    run_check("busywr", 2, 1, 16'hBEEF);
    run_check("startwr", 1, 2, 16'h1234);

    // randomized programs, keys, responder delays and counts (incl. clamp)
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < DEPTH; a++) begin
        prog_m[a] = 16'($urandom);
        write_mem(a, prog_m[a]);
      end
      okey = 16'($urandom);
      lo_d = $urandom_range(1, 3);
      hi_d = $urandom_range(1, 5);
      n = (r == 0) ? 2 * DEPTH - 1 : $urandom_range(1, 2 * DEPTH - 1);
      run_check("rand", n, 0, 16'h0);
    end

    // reset while the feeder is in STRT
    lo_d = 1; hi_d = 4;
    do_start(2);
    cyc = 0;
    while (bif.load !== 1'b1 && cyc < 10) begin tick(); cyc++; end
    chk("rstrt.load_seen", {31'b0, bif.load}, 1);
    reset = 1'b1;
    #1;
    chk("rstrt.s", {31'b0, bif.s}, 0);
    chk("rstrt.load", {31'b0, bif.load}, 0);
    chk("rstrt.busy", {31'b0, busy}, 0);
    chk("rstrt.pc", {28'b0, pc}, 0);
    tick();
    chk("rstrt.s_next", {31'b0, bif.s}, 0);
    reset = 1'b0;
    tick(); tick();
    chk("rstrt.idle_busy", {31'b0, busy}, 0);
    chk("rstrt.idle_done", {31'b0, done}, 0);
    run_check("recover", 1, 0, 16'h0);
    chk("overlap", {31'b0, overlap}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
